// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch stage. It holds the fetch PC, issues sequential requests to
// an instruction memory with one cycle of latency, buffers the returned
// {pc, instr} pairs in a small prefetch FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes stale work and restarts fetch at
// redirect_pc.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (overrides redirect)
//   imem_req     fetch request this cycle
//   imem_addr    fetch address, always equal to the fetch PC
//   imem_rdata   instruction word, valid the cycle after a request
//   redirect     taken branch/jump: flush and restart
//   redirect_pc  new fetch target
//   out_valid    queue head valid
//   out_ready    decode accepts the head
//   out_instr    head instruction, 0 when the queue is empty
//   out_pc       head PC, 0 when the queue is empty
//   out_pc_next  out_pc + PC_STEP (wrapping), 0 when the queue is empty
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_next
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam int                PTR_W     = IDX_W + 1;
    localparam int                OCC_W     = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              kill;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              pop;
    logic              push;
    logic              issue;

    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];

    // The pointers carry an extra wrap bit, so their difference is the fill
    // level directly and full (DEPTH) is distinguishable from empty (0).
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // A response is dropped if it belongs to work that a redirect has just
    // invalidated: either the redirect is happening right now, or it happened
    // last cycle (kill).
    assign push = inflight & ~kill & ~redirect;

    // Issue only when the request already in flight, plus this one, is sure
    // to find room. Counting the pop lets a full queue that is draining keep
    // fetching at full rate.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = ~rst & ~redirect & (occupancy < DEPTH_OCC);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    // Control state: fetch PC, the PC of the outstanding request, the
    // in-flight and kill flags, and the FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            kill     <= redirect;

            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + STEP;
            end

            if (issue) begin
                req_pc <= fetch_pc;
            end

            // A flush discards everything, including a head that is being
            // handed over in the same cycle; that handshake has already
            // completed on the decode side.
            if (redirect) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset; an entry is only visible once a push has
    // written it and the write pointer has moved past it.
    always_ff @(posedge clk) begin
        if (push & ~rst) begin
            pc_q[wr_ptr[IDX_W-1:0]]    <= req_pc;
            instr_q[wr_ptr[IDX_W-1:0]] <= imem_rdata;
        end
    end

    // Head presentation, forced to zero while the queue is empty.
    always_comb begin
        out_instr   = '0;
        out_pc      = '0;
        out_pc_next = '0;
        if (out_valid) begin
            out_instr   = instr_q[rd_ptr[IDX_W-1:0]];
            out_pc      = pc_q[rd_ptr[IDX_W-1:0]];
            out_pc_next = pc_q[rd_ptr[IDX_W-1:0]] + STEP;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit (default parameters). A behavioural
// instruction memory answers every address one cycle later with
// addr ^ 32'hC0DE_0000. Each cycle: inputs are driven 1 time unit after the
// rising edge and outputs are checked 1 unit later.
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;

    int total;
    int bad;

    fetch_queue_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model with one cycle of read latency.
    always @(posedge clk) begin
        imem_rdata <= instr_of(imem_addr);
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Advance to 1 unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then return at the start of cycle 0.
    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    // Reset state, with redirect also asserted to show reset wins.
    task automatic test_reset();
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        out_ready   = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req: actual=%0b required=0", imem_req);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid: actual=%0b required=0", out_valid);
        end
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_addr: actual=%h required=0", imem_addr);
        end
        total++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc_next !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: actual=%h/%h/%h required=0/0/0", out_pc, out_instr, out_pc_next);
        end
        redirect = 1'b0;
    endtask

    // Streaming with out_ready held high: one instruction per cycle from cycle 2.
    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
                bad++;
                $display("[TB] FAIL stream_req c%0d: actual=%0b/%h required=1/%h", c, imem_req, imem_addr, 32'(4 * c));
            end
            total++;
            if (out_valid !== (c >= 2)) begin
                bad++;
                $display("[TB] FAIL stream_valid c%0d: actual=%0b required=%0b", c, out_valid, (c >= 2));
            end
            if (c >= 2) begin
                exp_pc = 32'(4 * (c - 2));
                total++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc) || out_pc_next !== exp_pc + 32'd4) begin
                    bad++;
                    $display("[TB] FAIL stream_head c%0d: actual=%h/%h/%h required=%h/%h/%h", c, out_pc, out_instr, out_pc_next, exp_pc, instr_of(exp_pc), exp_pc + 32'd4);
                end
            end else begin
                total++;
                if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc_next !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL stream_empty c%0d: actual=%h/%h/%h required=0/0/0", c, out_pc, out_instr, out_pc_next);
                end
            end
            next_cycle();
        end
    endtask

    // Stall: exactly DEPTH issues, head stable, then in-order drain.
    task automatic test_stall();
        int issues;
        issues = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imem_req === 1'b1) issues++;
            if (c >= 2) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== instr_of(32'h0)) begin
                    bad++;
                    $display("[TB] FAIL stall_head c%0d: actual=%0b/%h/%h required=1/0/%h", c, out_valid, out_pc, out_instr, instr_of(32'h0));
                end
            end
            next_cycle();
        end
        total++;
        if (issues !== 4) begin
            bad++;
            $display("[TB] FAIL stall_issues: actual=%0d required=4", issues);
        end
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin
            bad++;
            $display("[TB] FAIL stall_full: actual=%0b/%h required=0/10", imem_req, imem_addr);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_pop_issue: actual=%0b required=1", imem_req);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
                bad++;
                $display("[TB] FAIL drain k%0d: actual=%0b/%h required=1/%h", k, out_valid, out_pc, 32'(4 * k));
            end
            next_cycle();
            #1;
        end
    endtask

    // Redirect with three entries queued and a response in flight.
    task automatic test_redirect_flush();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            next_cycle();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_R: actual=%0b/%0b required=0/1", imem_req, out_valid);
        end
        next_cycle();
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("[TB] FAIL flush_R1: actual=%0b/%0b/%h required=0/1/100", out_valid, imem_req, imem_addr);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_R2: actual=%0b required=0", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * k) || out_instr !== instr_of(32'h100 + 32'(4 * k))) begin
                bad++;
                $display("[TB] FAIL flush_R%0d: actual=%0b/%h/%h required=1/%h", k + 3, out_valid, out_pc, out_instr, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    // Redirect in the same cycle as a head handshake.
    task automatic test_redirect_pop();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            next_cycle();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
            bad++;
            $display("[TB] FAIL rpop_head: actual=%0b/%h required=1/4", out_valid, out_pc);
        end
        next_cycle();
        redirect = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k <= 2) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rpop_stale R%0d: actual=%0b/%h required=0", k, out_valid, out_pc);
                end
            end else begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * (k - 3))) begin
                    bad++;
                    $display("[TB] FAIL rpop_new R%0d: actual=%0b/%h required=1/%h", k, out_valid, out_pc, 32'h200 + 32'(4 * (k - 3)));
                end
            end
            next_cycle();
        end
    endtask

    // Redirect near the top of the address space: PC wraps to zero.
    task automatic test_wrap();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_R: actual=%0b required=0", imem_req);
        end
        next_cycle();
        redirect = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
            total++;
            if (imem_addr !== exp_addr) begin
                bad++;
                $display("[TB] FAIL wrap_addr c%0d: actual=%h required=%h", c, imem_addr, exp_addr);
            end
            if (c >= 3) begin
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
                total++;
                if (out_valid !== 1'b1 || out_pc !== exp_pc || out_pc_next !== exp_pc + 32'd4) begin
                    bad++;
                    $display("[TB] FAIL wrap_head c%0d: actual=%0b/%h/%h required=1/%h/%h", c, out_valid, out_pc, out_pc_next, exp_pc, exp_pc + 32'd4);
                end
            end
            next_cycle();
        end
    endtask

    // Two redirects in a row: only the second target is fetched.
    task automatic test_back_to_back();
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        #1;
        next_cycle();
        redirect_pc = 32'h400;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_second: actual=%0b required=0", imem_req);
        end
        next_cycle();
        redirect = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            bad++;
            $display("[TB] FAIL b2b_req: actual=%0b/%h required=1/400", imem_req, imem_addr);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_gap: actual=%0b/%h required=0", out_valid, out_pc);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            bad++;
            $display("[TB] FAIL b2b_first: actual=%0b/%h required=1/400", out_valid, out_pc);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h404) begin
            bad++;
            $display("[TB] FAIL b2b_second_out: actual=%0b/%h required=1/404", out_valid, out_pc);
        end
    endtask

    // Reset with a full queue: old entries vanish, fetch restarts at 0.
    task automatic test_reset_mid();
        do_reset();
        out_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h700;
        #1;
        next_cycle();
        redirect = 1'b0;
        for (int c = 1; c < 6; c++) begin
            #1;
            next_cycle();
        end
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h700 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_full: actual=%0b/%h/%0b required=1/700/0", out_valid, out_pc, imem_req);
        end
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_rst_req: actual=%0b required=0", imem_req);
        end
        next_cycle();
        rst       = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rmid_after: actual=%0b/%0b/%h required=0/1/0", out_valid, imem_req, imem_addr);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_stale: actual=%0b/%h required=0", out_valid, out_pc);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rmid_first: actual=%0b/%h required=1/0", out_valid, out_pc);
        end
        next_cycle();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
            bad++;
            $display("[TB] FAIL rmid_second: actual=%0b/%h required=1/4", out_valid, out_pc);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
